// File: rtl/multi_ch_func_gen.sv
// Time-multiplexed multi-channel function generator (sine/cosine/triangle/square) feeding a FIFO.
// Optional build macro FUNC_GEN_FREQ_STEP_EN adds a global phase-step input step_i.
module multi_ch_func_gen #(
   parameter  int DATA_WIDTH = 16,
   parameter  int LUT_ADDR   = 6,
   parameter  int INT_BITS   = 8,
   parameter  int NUM_CH     = 4,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic                         stop_i,
   input  logic                         conf_i,
   input  logic [CH_W-1:0]              conf_ch_i,
   input  logic signed [INT_BITS-1:0]   amp_i,
   input  logic [1:0]                   sel_i,
   input  logic [LUT_ADDR-1:0]          phase_i,
`ifdef FUNC_GEN_FREQ_STEP_EN
   input  logic [LUT_ADDR-1:0]          step_i,
`endif
   input  logic                         full_i,
   output logic                         wr_en_o,
   output logic signed [DATA_WIDTH-1:0] data_o,
   output logic [CH_W-1:0]              ch_o
);

   localparam int  N    = 1 << LUT_ADDR;
   localparam int  MAXV = (1 << (DATA_WIDTH - 1)) - 1;
   localparam int  PW   = DATA_WIDTH + INT_BITS;
   localparam real PI   = 3.14159265358979323846;

   localparam logic signed [DATA_WIDTH-1:0] WMAX    = DATA_WIDTH'(MAXV);
   localparam logic [LUT_ADDR-1:0]          QTR     = LUT_ADDR'(N / 4);
   localparam logic [CH_W-1:0]              CH_LAST = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, CONFI, GEN} state_t;

   // Elaboration-time sine point, rounded half away from zero.
   function automatic int sine_pt(input int i);
      real r;
      r = real'(MAXV) * $sin(2.0 * PI * real'(i) / real'(N));
      return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] tri_wave(input logic [LUT_ADDR-1:0] e);
      int     t;
      longint v;
      t = (int'(e) < N / 2) ? (2 * int'(e) - N / 2) : (3 * N / 2 - 2 * int'(e));
      v = longint'(t) <<< (DATA_WIDTH - LUT_ADDR);
      if (v > longint'(MAXV))
         v = longint'(MAXV);
      else if (v < -longint'(MAXV))
         v = -longint'(MAXV);
      return DATA_WIDTH'(v);
   endfunction

   // Symmetric wave range keeps the shifted product inside DATA_WIDTH.
   function automatic logic signed [DATA_WIDTH-1:0] scale_amp(
      input logic signed [DATA_WIDTH-1:0] wave,
      input logic signed [INT_BITS-1:0]   amp
   );
      logic signed [PW-1:0] prod;
      prod = PW'(wave) * PW'(amp);
      prod = prod >>> (INT_BITS - 1);
      return DATA_WIDTH'(prod);
   endfunction

   logic signed [DATA_WIDTH-1:0] sine_lut [N];

   for (genvar i = 0; i < N; i++) begin : g_sine
      localparam int S = sine_pt(i);
      assign sine_lut[i] = DATA_WIDTH'(S);
   end

   state_t state, state_nx;
   logic   emit, gen_enter;

   logic [LUT_ADDR-1:0]        base_p0;
   logic [CH_W-1:0]            ch_cnt;
   logic [LUT_ADDR-1:0]        step;

   logic signed [INT_BITS-1:0] amp_r   [NUM_CH];
   logic [1:0]                 sel_r   [NUM_CH];
   logic [LUT_ADDR-1:0]        phase_r [NUM_CH];

   logic signed [INT_BITS-1:0] cfg_amp;
   logic [1:0]                 cfg_sel;
   logic [LUT_ADDR-1:0]        cfg_phase;
   logic [CH_W-1:0]            cfg_ch;

   logic [LUT_ADDR-1:0]          eff_addr_p0, cos_addr_p0;
   logic signed [DATA_WIDTH-1:0] wave_p0, sample_p0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      emit      = 1'b0;
      gen_enter = 1'b0;
      case (state)
         IDLE: begin
            if (conf_i)
               state_nx = CONFI;
            else if (start_i) begin
               state_nx  = GEN;
               gen_enter = 1'b1;
            end
         end
         CONFI: state_nx = IDLE;
         GEN: begin
            if (stop_i)
               state_nx = IDLE;
            else
               emit = ~full_i;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Configuration is captured on the IDLE->CONFI edge and committed during CONFI.
   always_ff @(posedge clk) begin
      if (state == IDLE && conf_i) begin
         cfg_amp   <= amp_i;
         cfg_sel   <= sel_i;
         cfg_phase <= phase_i;
         cfg_ch    <= conf_ch_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            amp_r[i]   <= '0;
            sel_r[i]   <= '0;
            phase_r[i] <= '0;
         end
      end else if (state == CONFI) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
               amp_r[i]   <= cfg_amp;
               sel_r[i]   <= cfg_sel;
               phase_r[i] <= cfg_phase;
            end
         end
      end
   end

`ifdef FUNC_GEN_FREQ_STEP_EN
   logic [LUT_ADDR-1:0] cfg_step;

   always_ff @(posedge clk) begin
      if (state == IDLE && conf_i)
         cfg_step <= step_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         step <= LUT_ADDR'(1);
      else if (state == CONFI)
         step <= (cfg_step == '0) ? LUT_ADDR'(1) : cfg_step;
   end
`else
   assign step = LUT_ADDR'(1);
`endif

   // Base address advances only when the channel counter wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_p0 <= '0;
         ch_cnt  <= '0;
      end else if (gen_enter) begin
         base_p0 <= '0;
         ch_cnt  <= '0;
      end else if (emit) begin
         if (ch_cnt == CH_LAST) begin
            ch_cnt  <= '0;
            base_p0 <= base_p0 + step;
         end else begin
            ch_cnt <= ch_cnt + CH_W'(1);
         end
      end
   end

   always_comb begin
      eff_addr_p0 = base_p0 + phase_r[ch_cnt];
      cos_addr_p0 = eff_addr_p0 + QTR;
      wave_p0     = '0;
      case (sel_r[ch_cnt])
         2'b00:   wave_p0 = sine_lut[eff_addr_p0];
         2'b01:   wave_p0 = sine_lut[cos_addr_p0];
         2'b10:   wave_p0 = tri_wave(eff_addr_p0);
         default: wave_p0 = eff_addr_p0[LUT_ADDR-1] ? -WMAX : WMAX;
      endcase
      sample_p0 = scale_amp(wave_p0, amp_r[ch_cnt]);
   end

   // p0 -> p1: registered FIFO write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_o <= 1'b0;
         data_o  <= '0;
         ch_o    <= '0;
      end else begin
         wr_en_o <= emit;
         if (emit) begin
            data_o <= sample_p0;
            ch_o   <= ch_cnt;
         end
      end
   end

endmodule
